// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - imm_pkg: immediate format codes, opcodes, stage flags and opcode decoder
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_NONE = 3'b101,
    IMM_BAD  = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Width-independent part of the stage bundle; imm and tag widths come from the pipe.
  typedef struct packed {
    logic [2:0] fmt;
    logic       illegal;
  } imm_flags_t;

  function automatic logic [2:0] imm_decode(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return IMM_I;
      OPC_STORE:                                  return IMM_S;
      OPC_BRANCH:                                 return IMM_B;
      OPC_JAL:                                    return IMM_J;
      OPC_LUI, OPC_AUIPC:                         return IMM_U;
      OPC_OP:                                     return IMM_NONE;
      default:                                    return IMM_BAD;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_extend_comb.sv
// rtl/imm_extend_comb.sv - combinational immediate extraction and sign extension for one format code
module imm_extend_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic signed [31:0] v;

  always_comb begin
    v       = '0;
    illegal = 1'b0;
    case (fmt)
      IMM_I:    v = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:    v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:    v = {instr[31:12], 12'b0};
      IMM_NONE: v = '0;
      default:  illegal = 1'b1;
    endcase
    // v is signed, so widening to XLEN replicates bit 31.
    imm = XLEN'(v);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer; IMM_ERR_CNT_EN adds err_count
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int TAG_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  imm_gen_pipe_if.slave bus
`ifdef IMM_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_flags_t       flags;
    logic [TAG_W-1:0] tag;
  } bundle_t;

  logic            m_valid, s_valid;
  bundle_t         m_q, s_q, new_b;
  logic [2:0]      fmt_sel;
  logic [XLEN-1:0] ext_imm;
  logic            ext_ill;
  logic            accept, pop;

  assign fmt_sel = (AUTO_DECODE != 0) ? imm_decode(bus.in_instr[6:0]) : bus.in_imm_src;

  imm_extend_comb #(.XLEN(XLEN)) u_ext (
    .instr   (bus.in_instr[31:7]),
    .fmt     (fmt_sel),
    .imm     (ext_imm),
    .illegal (ext_ill)
  );

  always_comb begin
    new_b               = '0;
    new_b.imm           = ext_imm;
    new_b.flags.fmt     = fmt_sel;
    new_b.flags.illegal = ext_ill;
    new_b.tag           = bus.in_tag;
  end

  // in_ready only looks at the skid slot, so out_ready never reaches it combinationally.
  assign bus.in_ready = !reset && !s_valid;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = m_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (accept) begin
      if (!m_valid || bus.out_ready) begin
        m_valid <= 1'b1;
        m_q     <= new_b;
      end else begin
        s_valid <= 1'b1;
        s_q     <= new_b;
      end
    end else if (pop) begin
      if (s_valid) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = m_valid;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_fmt     = m_q.flags.fmt;
  assign bus.out_illegal = m_q.flags.illegal;
  assign bus.out_tag     = m_q.tag;

`ifdef IMM_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && ext_ill && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
